// File: rtl/beagleg_pkg.sv
// Shared types for the segment step sequencer: FSM states, record layout and decoded segment.
// SETUP only exists when STEP_SEQ_DIR_SETUP_EN is defined.
package beagleg_pkg;

    localparam int RECORD_WORDS   = 4;
    localparam int FIFO_WORD_SIZE = 8;

    localparam int BYTE_MASK_DIR = 0;
    localparam int BYTE_COUNT_LO = 1;
    localparam int BYTE_COUNT_HI = 2;
    localparam int BYTE_PERIOD   = 3;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        LOAD  = 3'd2,
        RUN   = 3'd3,
`ifdef STEP_SEQ_DIR_SETUP_EN
        DONE  = 3'd4,
        SETUP = 3'd5
`else
        DONE  = 3'd4
`endif
    } seq_state_t;

    typedef struct packed {
        logic [3:0]  mask;
        logic [3:0]  dir;
        logic [15:0] count;
        logic [7:0]  period;
    } segment_t;

    typedef logic [RECORD_WORDS-1:0][FIFO_WORD_SIZE-1:0] record_t;

    function automatic segment_t decode_record(input record_t rec);
        segment_t seg;
        seg.mask   = rec[BYTE_MASK_DIR][3:0];
        seg.dir    = rec[BYTE_MASK_DIR][7:4];
        seg.count  = {rec[BYTE_COUNT_HI], rec[BYTE_COUNT_LO]};
        seg.period = rec[BYTE_PERIOD];
        return seg;
    endfunction

endpackage

// File: rtl/step_timer.sv
// Period counter and step pulse generator for one segment; loaded in LOAD, counts
// down the remaining steps while running and flags the end of the final period.
module step_timer #(
    parameter int NUM_AXES    = 4,
    parameter int PRESCALE    = 16,
    parameter int PULSE_WIDTH = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                load_i,
    input  logic                run_i,
    input  logic [NUM_AXES-1:0] mask_i,
    input  logic [15:0]         count_i,
    input  logic [7:0]          period_i,
    output logic [NUM_AXES-1:0] step_o,
    output logic                last_step_done_o
);

    // Wide enough for the longest period, 256 * PRESCALE clocks.
    localparam int PERIOD_W = $clog2(256 * PRESCALE) + 1;

    logic [PERIOD_W-1:0] period_q, period_d;
    logic [PERIOD_W-1:0] tick_q, tick_d;
    logic [15:0]         remaining_q, remaining_d;
    logic [NUM_AXES-1:0] mask_q, mask_d;
    logic                period_end;

    always_comb begin
        period_d         = period_q;
        tick_d           = tick_q;
        remaining_d      = remaining_q;
        mask_d           = mask_q;
        last_step_done_o = 1'b0;
        period_end       = (tick_q == period_q - PERIOD_W'(1));

        if (load_i) begin
            period_d    = (PERIOD_W'(period_i) + PERIOD_W'(1)) * PERIOD_W'(PRESCALE);
            tick_d      = '0;
            remaining_d = count_i;
            mask_d      = mask_i;
        end else if (run_i) begin
            if (period_end) begin
                tick_d           = '0;
                remaining_d      = remaining_q - 16'd1;
                last_step_done_o = (remaining_q == 16'd1);
            end else begin
                tick_d = tick_q + PERIOD_W'(1);
            end
        end

        step_o = (run_i && (tick_q < PERIOD_W'(PULSE_WIDTH))) ? mask_q : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            period_q    <= '0;
            tick_q      <= '0;
            remaining_q <= '0;
            mask_q      <= '0;
        end else begin
            period_q    <= period_d;
            tick_q      <= tick_d;
            remaining_q <= remaining_d;
            mask_q      <= mask_d;
        end
    end

endmodule

// File: rtl/segment_step_sequencer.sv
// Sole reader of the segment FIFO: fetches 4-byte records, decodes them and drives step/dir.
// Optional direction setup delay is enabled by defining STEP_SEQ_DIR_SETUP_EN.
module segment_step_sequencer #(
    parameter int WORD_SIZE    = 8,
    parameter int RECORD_WORDS = 4,
    parameter int FIFO_SIZE_W  = 7,
    parameter int NUM_AXES     = 4,
    parameter int PRESCALE     = 16,
    parameter int PULSE_WIDTH  = 4,
    parameter int DIR_SETUP    = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   enable,
    input  logic                   clear_status,
    input  logic [FIFO_SIZE_W-1:0] fifo_size,
    input  logic [WORD_SIZE-1:0]   fifo_data,
    output logic                   fifo_read_en,
    output logic [NUM_AXES-1:0]    step,
    output logic [NUM_AXES-1:0]    dir,
    output logic                   busy,
    output logic                   underrun,
    output logic [15:0]            segments_done
);

    import beagleg_pkg::*;

    localparam int IDX_W  = $clog2(RECORD_WORDS + 1);
    localparam int BYTE_W = $clog2(RECORD_WORDS);

    if (WORD_SIZE != FIFO_WORD_SIZE || RECORD_WORDS != beagleg_pkg::RECORD_WORDS ||
        NUM_AXES < 1 || NUM_AXES > 4 || PRESCALE <= PULSE_WIDTH || DIR_SETUP < 1) begin : g_bad_params
        $error("segment_step_sequencer: unsupported parameter combination");
    end

    seq_state_t          state_q, state_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    record_t             rec_q, rec_d;
    logic [NUM_AXES-1:0] dir_q, dir_d;
    logic                underrun_q, underrun_d;
    logic [15:0]         done_cnt_q, done_cnt_d;

    segment_t            seg;
    logic [NUM_AXES-1:0] new_dir;
    logic [NUM_AXES-1:0] new_mask;
    logic                record_ready;
    logic                last_step_done;

`ifdef STEP_SEQ_DIR_SETUP_EN
    localparam int SETUP_W = $clog2(DIR_SETUP + 1);
    logic [SETUP_W-1:0] setup_q, setup_d;
`endif

    assign seg          = decode_record(rec_q);
    assign new_dir      = seg.dir[NUM_AXES-1:0];
    assign new_mask     = seg.mask[NUM_AXES-1:0];
    assign record_ready = (fifo_size >= FIFO_SIZE_W'(RECORD_WORDS));

    step_timer #(
        .NUM_AXES   (NUM_AXES),
        .PRESCALE   (PRESCALE),
        .PULSE_WIDTH(PULSE_WIDTH)
    ) u_step_timer (
        .clk             (clk),
        .rst_n           (rst_n),
        .load_i          (state_q == LOAD),
        .run_i           (state_q == RUN),
        .mask_i          (new_mask),
        .count_i         (seg.count),
        .period_i        (seg.period),
        .step_o          (step),
        .last_step_done_o(last_step_done)
    );

    // FETCH issues reads while idx < RECORD_WORDS and captures byte idx-1 one cycle later.
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        rec_d        = rec_q;
        dir_d        = dir_q;
        underrun_d   = underrun_q & ~clear_status;
        done_cnt_d   = done_cnt_q;
        fifo_read_en = 1'b0;
`ifdef STEP_SEQ_DIR_SETUP_EN
        setup_d      = setup_q;
`endif

        case (state_q)
            IDLE: begin
                if (enable && record_ready) begin
                    state_d = FETCH;
                    idx_d   = '0;
                end
            end
            FETCH: begin
                fifo_read_en = (idx_q < IDX_W'(RECORD_WORDS));
                if (idx_q != '0) begin
                    rec_d[BYTE_W'(idx_q - IDX_W'(1))] = fifo_data;
                end
                if (idx_q == IDX_W'(RECORD_WORDS)) begin
                    state_d = LOAD;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            LOAD: begin
                dir_d = new_dir;
                if (seg.count == 16'd0) begin
                    state_d = DONE;
                end else begin
`ifdef STEP_SEQ_DIR_SETUP_EN
                    if (new_dir != dir_q) begin
                        state_d = SETUP;
                        setup_d = '0;
                    end else begin
                        state_d = RUN;
                    end
`else
                    state_d = RUN;
`endif
                end
            end
            RUN: begin
                if (last_step_done) begin
                    state_d = DONE;
                end
            end
`ifdef STEP_SEQ_DIR_SETUP_EN
            SETUP: begin
                if (setup_q == SETUP_W'(DIR_SETUP - 1)) begin
                    state_d = RUN;
                end else begin
                    setup_d = setup_q + SETUP_W'(1);
                end
            end
`endif
            DONE: begin
                done_cnt_d = done_cnt_q + 16'd1;
                if (enable && record_ready) begin
                    state_d = FETCH;
                    idx_d   = '0;
                end else begin
                    state_d = IDLE;
                    if (enable) begin
                        underrun_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            rec_q      <= '0;
            dir_q      <= '0;
            underrun_q <= 1'b0;
            done_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            rec_q      <= rec_d;
            dir_q      <= dir_d;
            underrun_q <= underrun_d;
            done_cnt_q <= done_cnt_d;
        end
    end

`ifdef STEP_SEQ_DIR_SETUP_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            setup_q <= '0;
        end else begin
            setup_q <= setup_d;
        end
    end
`endif

    assign busy          = (state_q != IDLE);
    assign dir           = dir_q;
    assign underrun      = underrun_q;
    assign segments_done = done_cnt_q;

endmodule
